// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT MCU program-fetch slice.
`timescale 1ns/1ps
package rat_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        INTR  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        FROM_IMMED = 2'd0,
        FROM_STACK = 2'd1,
        FROM_INTR  = 2'd2
    } pc_sel_t;

    localparam int         RAT_ADDR_W     = 10;
    localparam logic [9:0] RAT_INT_VECTOR = 10'h3FF;
    localparam logic [9:0] RAT_RESET_ADDR = 10'h000;

endpackage

// File: rtl/program_counter.sv
// Program counter register with next-address mux; load takes priority over increment.
`timescale 1ns/1ps
module program_counter
    import rat_pkg::*;
#(
    parameter int                ADDR_W     = RAT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RAT_RESET_ADDR),
    parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(RAT_INT_VECTOR)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] FROM_IMMED,
    input  logic [ADDR_W-1:0] FROM_STACK,
    input  logic [1:0]        PC_MUX_SEL,
    input  logic              PC_LD,
    input  logic              PC_INC,
    output logic [ADDR_W-1:0] PC_COUNT
);

    logic [ADDR_W-1:0] pc_next_s;

    // Next-address selection; the reserved select code holds the PC.
    always_comb begin
        pc_next_s = PC_COUNT;
        if (PC_LD) begin
            case (PC_MUX_SEL)
                rat_pkg::FROM_IMMED: pc_next_s = FROM_IMMED;
                rat_pkg::FROM_STACK: pc_next_s = FROM_STACK;
                rat_pkg::FROM_INTR:  pc_next_s = INT_VECTOR;
                default:             pc_next_s = PC_COUNT;
            endcase
        end else if (PC_INC) begin
            pc_next_s = PC_COUNT + ADDR_W'(1);
        end else begin
            pc_next_s = PC_COUNT;
        end
    end

    // PC register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC_COUNT <= RESET_ADDR;
        end else begin
            PC_COUNT <= pc_next_s;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// FETCH/EXEC/INTR sequencer around the program counter; hides the ROM's one-cycle read latency.
`timescale 1ns/1ps
module pc_fetch_unit
    import rat_pkg::*;
#(
    parameter int                ADDR_W     = RAT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RAT_RESET_ADDR),
    parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(RAT_INT_VECTOR)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] FROM_IMMED,
    input  logic [ADDR_W-1:0] FROM_STACK,
    input  logic [1:0]        PC_MUX_SEL,
    input  logic              PC_LD,
    input  logic              PC_INC,
    input  logic              STALL,
    input  logic              INT_REQ,
    input  logic              INT_EN,
    output logic [ADDR_W-1:0] PC_COUNT,
    output logic              IR_VALID,
    output logic              INT_ACK,
    output logic [ADDR_W-1:0] SAVED_PC
);

    fetch_state_t      state_r;
    logic              ir_valid_r;
    logic              int_ack_r;
    logic              pc_ld_s;
    logic              pc_inc_s;
    logic [1:0]        pc_sel_s;
    logic [ADDR_W-1:0] pc_count_s;

    // PC control is only honoured in an unstalled EXEC; INTR forces the vector load.
    always_comb begin
        pc_ld_s  = 1'b0;
        pc_inc_s = 1'b0;
        pc_sel_s = PC_MUX_SEL;
        case (state_r)
            EXEC: begin
                if (!STALL) begin
                    pc_ld_s  = PC_LD;
                    pc_inc_s = PC_INC;
                end else begin
                    pc_ld_s  = 1'b0;
                    pc_inc_s = 1'b0;
                end
            end
            INTR: begin
                pc_ld_s  = 1'b1;
                pc_sel_s = rat_pkg::FROM_INTR;
            end
            default: begin
                pc_ld_s  = 1'b0;
                pc_inc_s = 1'b0;
            end
        endcase
    end

    // Sequencer with IR_VALID/INT_ACK registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= FETCH;
            ir_valid_r <= 1'b0;
            int_ack_r  <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    state_r    <= EXEC;
                    ir_valid_r <= 1'b1;
                    int_ack_r  <= 1'b0;
                end
                EXEC: begin
                    if (STALL) begin
                        state_r    <= EXEC;
                        ir_valid_r <= 1'b1;
                        int_ack_r  <= 1'b0;
                    end else if (INT_REQ && INT_EN) begin
                        state_r    <= INTR;
                        ir_valid_r <= 1'b0;
                        int_ack_r  <= 1'b1;
                    end else begin
                        state_r    <= FETCH;
                        ir_valid_r <= 1'b0;
                        int_ack_r  <= 1'b0;
                    end
                end
                INTR: begin
                    state_r    <= FETCH;
                    ir_valid_r <= 1'b0;
                    int_ack_r  <= 1'b0;
                end
                default: begin
                    state_r    <= FETCH;
                    ir_valid_r <= 1'b0;
                    int_ack_r  <= 1'b0;
                end
            endcase
        end
    end

    program_counter #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (RESET_ADDR),
        .INT_VECTOR (INT_VECTOR)
    ) u_program_counter (
        .CLK        (CLK),
        .RST        (RST),
        .FROM_IMMED (FROM_IMMED),
        .FROM_STACK (FROM_STACK),
        .PC_MUX_SEL (pc_sel_s),
        .PC_LD      (pc_ld_s),
        .PC_INC     (pc_inc_s),
        .PC_COUNT   (pc_count_s)
    );

    assign PC_COUNT = pc_count_s;
    assign SAVED_PC = pc_count_s;
    assign IR_VALID = ir_valid_r;
    assign INT_ACK  = int_ack_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a cycle-level reference model and literal spot checks.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic       CLK;
    logic       RST;
    logic [9:0] FROM_IMMED;
    logic [9:0] FROM_STACK;
    logic [1:0] PC_MUX_SEL;
    logic       PC_LD;
    logic       PC_INC;
    logic       STALL;
    logic       INT_REQ;
    logic       INT_EN;
    logic [9:0] PC_COUNT;
    logic       IR_VALID;
    logic       INT_ACK;
    logic [9:0] SAVED_PC;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int P_FETCH = 0;
    localparam int P_EXEC  = 1;
    localparam int P_INTR  = 2;

    int m_pc    = 0;
    int m_phase = P_FETCH;

    pc_fetch_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .FROM_IMMED (FROM_IMMED),
        .FROM_STACK (FROM_STACK),
        .PC_MUX_SEL (PC_MUX_SEL),
        .PC_LD      (PC_LD),
        .PC_INC     (PC_INC),
        .STALL      (STALL),
        .INT_REQ    (INT_REQ),
        .INT_EN     (INT_EN),
        .PC_COUNT   (PC_COUNT),
        .IR_VALID   (IR_VALID),
        .INT_ACK    (INT_ACK),
        .SAVED_PC   (SAVED_PC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the spec says each instruction does to the PC and phase.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pc    <= 0;
            m_phase <= P_FETCH;
        end else if (m_phase == P_FETCH) begin
            m_phase <= P_EXEC;
        end else if (m_phase == P_EXEC) begin
            if (!STALL) begin
                if (PC_LD) begin
                    if (PC_MUX_SEL == 2'd0)      m_pc <= int'(FROM_IMMED);
                    else if (PC_MUX_SEL == 2'd1) m_pc <= int'(FROM_STACK);
                    else if (PC_MUX_SEL == 2'd2) m_pc <= 1023;
                end else if (PC_INC) begin
                    m_pc <= (m_pc + 1) % 1024;
                end
                m_phase <= (INT_REQ && INT_EN) ? P_INTR : P_FETCH;
            end
        end else begin
            m_pc    <= 1023;
            m_phase <= P_FETCH;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("pc_count", 32'(PC_COUNT), m_pc);
        check("ir_valid", 32'(IR_VALID), (m_phase == P_EXEC) ? 1 : 0);
        check("int_ack",  32'(INT_ACK),  (m_phase == P_INTR) ? 1 : 0);
        if (m_phase == P_INTR) check("saved_pc", 32'(SAVED_PC), m_pc);
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; FROM_IMMED = 10'h000; FROM_STACK = 10'h000; PC_MUX_SEL = 2'd0;
        PC_LD = 1'b0; PC_INC = 1'b0; STALL = 1'b0; INT_REQ = 1'b0; INT_EN = 1'b0;
        cyc();
        check("lit_rst_pc",    32'(PC_COUNT), 32'h000);
        check("lit_rst_ir",    32'(IR_VALID), 32'd0);
        check("lit_rst_ack",   32'(INT_ACK),  32'd0);
        check("lit_rst_saved", 32'(SAVED_PC), 32'h000);
        RST = 1'b0;
        // Alternating FETCH/EXEC with no PC control
        cyc(); check("lit_tog1", 32'(IR_VALID), 32'd1);
        cyc(); check("lit_tog2", 32'(IR_VALID), 32'd0);
        cyc(); check("lit_tog3", 32'(IR_VALID), 32'd1);
        PC_LD = 1'b1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h005;
        cyc(); check("lit_ld5", 32'(PC_COUNT), 32'h005);
        PC_LD = 1'b0;
        cyc(); check("lit_exec5", 32'(IR_VALID), 32'd1);
        // Asynchronous reset mid-EXEC
        #2 RST = 1'b1;
        #1;
        check("lit_arst_pc", 32'(PC_COUNT), 32'h000);
        check("lit_arst_ir", 32'(IR_VALID), 32'd0);
        cyc(); check("lit_arst_hold", 32'(IR_VALID), 32'd0);
        RST = 1'b0;
        cyc(); check("lit_rel1", 32'(IR_VALID), 32'd1);
        cyc(); check("lit_rel2", 32'(IR_VALID), 32'd0);
        cyc(); check("lit_rel3", 32'(IR_VALID), 32'd1);
        // Sequential increment across the wrap
        PC_LD = 1'b1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h3FE;
        cyc(); PC_LD = 1'b0; PC_INC = 1'b1;
        cyc(); check("lit_wrap_3fe", 32'(PC_COUNT), 32'h3FE);
        cyc(); check("lit_wrap_3ff", 32'(PC_COUNT), 32'h3FF);
        cyc();
        cyc(); check("lit_wrap_000", 32'(PC_COUNT), 32'h000);
        cyc();
        // Load beats increment; reserved select holds
        PC_LD = 1'b1; PC_INC = 1'b1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h123;
        cyc(); check("lit_immed", 32'(PC_COUNT), 32'h123);
        PC_MUX_SEL = 2'd1; FROM_STACK = 10'h045;
        cyc();
        cyc(); check("lit_stack", 32'(PC_COUNT), 32'h045);
        PC_MUX_SEL = 2'd3;
        cyc();
        cyc(); check("lit_sel3", 32'(PC_COUNT), 32'h045);
        PC_MUX_SEL = 2'd2;
        cyc();
        cyc(); check("lit_sel2", 32'(PC_COUNT), 32'h3FF);
        cyc();
        // Three stalled cycles, then one increment
        PC_LD = 1'b0; PC_INC = 1'b1; STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("lit_stall_pc", 32'(PC_COUNT), 32'h3FF);
            check("lit_stall_ir", 32'(IR_VALID), 32'd1);
        end
        STALL = 1'b0;
        cyc(); check("lit_unstall", 32'(PC_COUNT), 32'h000);
        // Interrupt entry after an incrementing instruction at 0x010
        PC_LD = 1'b1; PC_INC = 1'b0; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h010;
        cyc();
        cyc(); PC_LD = 1'b0; PC_INC = 1'b1; INT_REQ = 1'b1; INT_EN = 1'b1;
        cyc(); check("lit_int_pc", 32'(PC_COUNT), 32'h010);
        cyc();
        check("lit_int_ack",   32'(INT_ACK),  32'd1);
        check("lit_int_saved", 32'(SAVED_PC), 32'h011);
        check("lit_int_ir",    32'(IR_VALID), 32'd0);
        INT_REQ = 1'b0;
        cyc();
        check("lit_int_vec",  32'(PC_COUNT), 32'h3FF);
        check("lit_int_ack0", 32'(INT_ACK),  32'd0);
        cyc();
        // Masked request is ignored
        INT_REQ = 1'b1; INT_EN = 1'b0;
        cyc(); check("lit_mask_ack", 32'(INT_ACK), 32'd0);
        check("lit_mask_pc", 32'(PC_COUNT), 32'h000);
        cyc();
        // Enabled request held off by stall
        INT_EN = 1'b1; STALL = 1'b1;
        cyc(); check("lit_stint_ack1", 32'(INT_ACK), 32'd0);
        cyc(); check("lit_stint_ack2", 32'(INT_ACK), 32'd0);
        STALL = 1'b0;
        cyc();
        check("lit_stint_ack", 32'(INT_ACK),  32'd1);
        check("lit_stint_sv",  32'(SAVED_PC), 32'h001);
        // Back-to-back entry while the request stays high
        cyc(); check("lit_b2b_vec", 32'(PC_COUNT), 32'h3FF);
        cyc();
        cyc();
        check("lit_b2b_ack", 32'(INT_ACK),  32'd1);
        check("lit_b2b_sv",  32'(SAVED_PC), 32'h000);
        INT_REQ = 1'b0;
        // Mixed vectors checked by the model only
        for (int i = 0; i < 80; i++) begin
            cyc();
            FROM_IMMED = 10'($urandom);
            FROM_STACK = 10'($urandom);
            PC_MUX_SEL = 2'($urandom);
            PC_LD      = 1'($urandom);
            PC_INC     = 1'($urandom);
            STALL      = ($urandom_range(0, 3) == 0);
            INT_REQ    = 1'($urandom);
            INT_EN     = 1'($urandom);
        end
        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream neighbour of the 1024x18 synchronous program ROM in the RAT MCU.
- Owns the 10-bit program counter, which drives the ROM address, and the next-address mux: immediate, stack return, or interrupt vector.
- Contains a FETCH/EXEC/INTR sequencer that absorbs the ROM's one-cycle read latency. It tells the control unit when the instruction register is valid and sequences interrupt entry.

Parameters:
- ADDR_W, 10, program address width (ROM depth 2^ADDR_W).
- RESET_ADDR, 10'h000, PC value after reset.
- INT_VECTOR, 10'h3FF, PC value loaded on interrupt entry.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- FROM_IMMED  in  ADDR_W  branch/call target from IR[12:3].
- FROM_STACK  in  ADDR_W  return address popped from scratch RAM.
- PC_MUX_SEL  in  2  0=FROM_IMMED, 1=FROM_STACK, 2=INT_VECTOR, 3=reserved.
- PC_LD  in  1  load PC from mux (EXEC only).
- PC_INC  in  1  increment PC (EXEC only).
- STALL  in  1  hold in EXEC; no PC update.
- INT_REQ  in  1  level interrupt request.
- INT_EN  in  1  interrupt enable (I flag).
- PC_COUNT  out  ADDR_W  registered PC; drives ROM PROG_ADDR.
- IR_VALID  out  1  high in EXEC: ROM output is the current instruction.
- INT_ACK  out  1  high for the single INTR cycle.
- SAVED_PC  out  ADDR_W  return address to push; valid only while INT_ACK=1.

Behaviour:
- Reset (async, any state, mid-instruction included): state=FETCH, PC=RESET_ADDR, IR_VALID=0, INT_ACK=0, SAVED_PC=0. The first ROM read is at RESET_ADDR on the first edge after RST deasserts.
- All outputs decode from registers (state, PC). There is no combinational path from inputs to outputs except SAVED_PC, which equals PC.

FETCH:
- PC holds; PC_LD, PC_INC and STALL are ignored. ROM captures rom[PC] at the edge.
- Next state is always EXEC.
- INT_REQ is not sampled.

EXEC:
- IR_VALID=1.
- If STALL=1: PC holds, state stays EXEC, and INT_REQ is not sampled.
- Otherwise, at the edge:
  - PC_LD=1 with sel 0/1/2: PC <= FROM_IMMED, FROM_STACK or INT_VECTOR respectively.
  - PC_LD=1 with sel 3: PC holds.
  - PC_LD=0 with PC_INC=1: PC <= PC+1 modulo 2^ADDR_W (3FF wraps to 000).
  - PC_LD has priority over PC_INC.
  - Neither asserted: PC holds.
  - Next state: INTR if INT_REQ & INT_EN, else FETCH.
- An instruction's own PC update completes before interrupt entry.

INTR:
- INT_ACK=1, IR_VALID=0, SAVED_PC=PC (the already-updated next-instruction address).
- At the edge: PC <= INT_VECTOR, next state FETCH.
- PC_LD, PC_INC, STALL and INT_REQ are ignored.

Latency and throughput:
- Fetch-to-valid is one cycle; one instruction takes two cycles (FETCH+EXEC); interrupt entry adds one cycle.

Boundary conditions:
- INT_REQ rising during FETCH or INTR is serviced at the next unstalled EXEC if still high.
- Clearing of INT_EN is the control unit's job. Back-to-back entry is possible if INT_REQ stays high and INT_EN stays 1.

Decomposition:
- Shared package rat_pkg holds:
  - fetch_state_t enum {FETCH, EXEC, INTR}
  - pc_sel_t enum {FROM_IMMED=2'd0, FROM_STACK=2'd1, FROM_INTR=2'd2}
  - constants RAT_ADDR_W=10, RAT_INT_VECTOR=10'h3FF.
- One sub-module, program_counter: PC register, next-address mux, PC_LD/PC_INC priority and async reset.
- pc_fetch_unit contains the sequencer and instantiates program_counter.

Test Plan:
- Reset: assert RST mid-EXEC with PC=0x05 -> immediately PC_COUNT=0x000, IR_VALID=0; after release, IR_VALID toggles 0,1,0,1 on successive cycles.
- Sequential/wrap: PC_INC=1 every EXEC from PC=0x3FE -> PC_COUNT goes 0x3FE, 0x3FF, 0x000 on successive EXEC exits.
- Branch/return priority: in EXEC, PC_LD=1, PC_INC=1, sel=0, FROM_IMMED=0x123 -> PC=0x123. Then sel=1, FROM_STACK=0x045 -> PC=0x045. Then sel=3 -> PC unchanged.
- Stall: STALL=1 for 3 cycles in EXEC with PC_INC=1 -> PC and IR_VALID=1 hold for 3 cycles; PC increments once on the first unstalled edge.
- Interrupt: PC=0x010, PC_INC=1, INT_REQ=1, INT_EN=1 in EXEC -> next cycle INT_ACK=1, SAVED_PC=0x011; following cycle PC=0x3FF in FETCH, INT_ACK=0.
- Masked/stalled interrupt: INT_EN=0 -> no INT_ACK. INT_EN=1 with STALL=1 -> no INTR entry until STALL drops.
